// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI-to-register-bus bridge.
package spi_pkg;

  localparam int SIZE_DEFAULT    = 8;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    CMD,
    WRITE,
    FETCH,
    READ
  } state_t;

  // The command word's top bit selects read (1) or write (0).
  function automatic int cmd_rd_bit(input int size);
    return size - 1;
  endfunction

  localparam int CMD_RD_BIT = cmd_rd_bit(SIZE_DEFAULT);

endpackage

// File: rtl/spi_idle_timer.sv
// Idle counter between frames: clears on demand, counts when enabled and
// pulses expire on the clock where it has reached timeout-1.
module spi_idle_timer
  import spi_pkg::*;
#(
  parameter int timeout = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (timeout > 2) ? $clog2(timeout) : 1;

  logic [W-1:0] count;

  assign expire = en && !clr && (count == W'(timeout - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns SPI shifter frames (command word, then data words) into register-bus
// read/write strobes with auto-incrementing address and read prefetch.
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int size    = SIZE_DEFAULT,
  parameter int timeout = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            spi_re,
  input  logic            spi_we,
  input  logic [size-1:0] spi_do,
  output logic [size-1:0] spi_di,
  output logic [size-2:0] bus_addr,
  output logic [size-1:0] bus_wdata,
  output logic            bus_we,
  output logic            bus_re,
  input  logic [size-1:0] bus_rdata,
  output logic            busy
);

  localparam int RD_BIT = cmd_rd_bit(size);

  state_t          state;
  logic [size-2:0] addr;
  logic            in_frame;
  logic            expire;

  assign bus_addr = addr;
  assign busy     = (state != CMD);

  spi_idle_timer #(
    .timeout(timeout)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (spi_re | spi_we | !busy),
    .en    (busy & !in_frame),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CMD;
      spi_di    <= '0;
      addr      <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      in_frame  <= 1'b0;
    end else begin
      // NOTE: strobes default low every clock so each is a single-cycle pulse;
      // all state here uses non-blocking assignment, later writes win.
      bus_we <= 1'b0;
      bus_re <= 1'b0;

      if (spi_re) begin
        in_frame <= 1'b1;
      end else if (spi_we) begin
        in_frame <= 1'b0;
      end

      // Write address advances the clock after its strobe has been seen.
      if (bus_we) begin
        addr <= addr + 1'b1;
      end

      if (expire) begin
        state  <= CMD;
        spi_di <= '0;
      end else begin
        case (state)
          CMD: begin
            if (spi_we) begin
              addr <= spi_do[size-2:0];
              if (spi_do[RD_BIT]) begin
                bus_re <= 1'b1;
                state  <= FETCH;
              end else begin
                state  <= WRITE;
              end
            end
          end
          WRITE: begin
            if (spi_we) begin
              bus_wdata <= spi_do;
              bus_we    <= 1'b1;
            end
          end
          FETCH: begin
            // First FETCH clock carries bus_re; read data lands on the second.
            if (!bus_re) begin
              spi_di <= bus_rdata;
              addr   <= addr + 1'b1;
              state  <= READ;
            end
          end
          READ: begin
            if (spi_we) begin
              bus_re <= 1'b1;
              state  <= FETCH;
            end
          end
          default: state <= CMD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomized bench for spi_reg_bridge against a transaction-level model of
// the command/data frame protocol and a simple register file.
module tb_spi_reg_bridge;

  localparam int SZ  = 8;
  localparam int TMO = 16;

  typedef enum int {M_CMD, M_WRITE, M_READ} mode_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_re, spi_we;
  logic [SZ-1:0] spi_do, spi_di;
  logic [SZ-2:0] bus_addr;
  logic [SZ-1:0] bus_wdata, bus_rdata;
  logic          bus_we, bus_re, busy;

  spi_reg_bridge #(.size(SZ), .timeout(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_re   (spi_re),
    .spi_we   (spi_we),
    .spi_do   (spi_do),
    .spi_di   (spi_di),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_rdata(bus_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 97 + 60) ^ (i >> 2));
  endfunction

  // Register file on the bus side: data returned one clock after bus_re.
  logic [7:0] regs [128];
  bit         seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 128; i++) regs[i] <= init_val(i);
      seeded <= 1'b1;
    end else if (bus_we) begin
      regs[bus_addr] <= bus_wdata;
    end
    bus_rdata <= bus_re ? regs[bus_addr] : 8'($urandom);
  end

  // Reference model state.
  logic [7:0] ref_mem [128];
  mode_t      mode   = M_CMD;
  logic [6:0] maddr  = '0;
  logic [7:0] tx_exp = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One NSS frame: host receives spi_di at start, sends w at end.
  task automatic frame(input logic [7:0] w, input int len, input int gap, input bit rst_mid);
    logic       exp_we, exp_re;
    logic [6:0] exp_a;
    logic [7:0] exp_d;
    spi_re = 1'b1;
    check("spi_di_at_re", spi_di, tx_exp);
    check("busy_at_re", busy, mode != M_CMD);
    @(negedge clk);
    spi_re = 1'b0;
    repeat (len) @(negedge clk);
    spi_do = w;
    spi_we = 1'b1;
    exp_we = 1'b0; exp_re = 1'b0; exp_a = '0; exp_d = '0;
    case (mode)
      M_CMD: begin
        maddr = w[6:0];
        if (w[7]) begin
          mode = M_READ; exp_re = 1'b1; exp_a = maddr;
          tx_exp = ref_mem[maddr]; maddr = maddr + 1'b1;
        end else begin
          mode = M_WRITE; tx_exp = 8'h00;
        end
      end
      M_WRITE: begin
        exp_we = 1'b1; exp_a = maddr; exp_d = w;
        ref_mem[maddr] = w; maddr = maddr + 1'b1;
      end
      default: begin
        exp_re = 1'b1; exp_a = maddr;
        tx_exp = ref_mem[maddr]; maddr = maddr + 1'b1;
      end
    endcase
    @(negedge clk);
    spi_we = 1'b0;
    spi_do = 8'($urandom);
    check("bus_we", bus_we, exp_we);
    check("bus_re", bus_re, exp_re);
    if (exp_we || exp_re) check("bus_addr", bus_addr, exp_a);
    if (exp_we) check("bus_wdata", bus_wdata, exp_d);
    if (rst_mid) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_bus_re", bus_re, 1'b0);
      check("rst_spi_di", spi_di, 8'h00);
      check("rst_busy", busy, 1'b0);
      mode = M_CMD; tx_exp = 8'h00;
    end else begin
      @(negedge clk);
      check("strobe_width", {bus_we, bus_re}, 2'b00);
    end
    repeat (gap) @(negedge clk);
    if (gap >= TMO) begin
      mode = M_CMD; tx_exp = 8'h00;
      check("busy_after_idle", busy, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    rst = 1'b1; spi_re = 1'b0; spi_we = 1'b0; spi_do = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_spi_di0", spi_di, 8'h00);
    check("rst_addr", bus_addr, 7'h00);
    check("rst_wdata", bus_wdata, 8'h00);
    check("rst_strobes", {bus_we, bus_re}, 2'b00);
    check("rst_busy0", busy, 1'b0);
    @(negedge clk);

    // Write burst.
    frame(8'h05, 3, 5, 1'b0);
    frame(8'h11, 3, 5, 1'b0);
    frame(8'h22, 2, 6, 1'b0);
    frame(8'h33, 4, TMO + 8, 1'b0);
    // Seed 0x10..0x12 then read them back as a burst.
    frame(8'h10, 2, 5, 1'b0);
    frame(8'hAA, 2, 5, 1'b0);
    frame(8'hBB, 2, 5, 1'b0);
    frame(8'hCC, 2, TMO + 8, 1'b0);
    frame(8'h90, 3, 5, 1'b0);
    frame(8'h5E, 3, 4, 1'b0);
    frame(8'h5E, 3, 6, 1'b0);
    frame(8'h5E, 3, TMO + 8, 1'b0);
    // Address wrap.
    frame(8'h7F, 2, 5, 1'b0);
    frame(8'h01, 2, 5, 1'b0);
    frame(8'h02, 2, TMO + 8, 1'b0);
    // Idle timeout, then the next word is a fresh command.
    frame(8'h03, 2, TMO + 8, 1'b0);
    frame(8'h44, 2, 5, 1'b0);
    frame(8'h5A, 2, TMO + 8, 1'b0);
    // Long frame does not time out.
    frame(8'h30, 2, 5, 1'b0);
    frame(8'h66, 40, TMO + 8, 1'b0);
    // Reset while fetching.
    frame(8'h90, 2, 5, 1'b0);
    frame(8'h00, 2, 6, 1'b1);
    frame(8'h20, 2, 5, 1'b0);
    frame(8'h77, 2, TMO + 8, 1'b0);

    for (int t = 0; t < 14; t++) begin
      int n;
      n = $urandom_range(1, 4);
      frame(8'($urandom), $urandom_range(1, 8), $urandom_range(4, 10), 1'b0);
      for (int k = 0; k < n; k++) begin
        frame(8'($urandom), $urandom_range(1, 8),
              (k == n - 1) ? TMO + 8 : $urandom_range(4, 10), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
